// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, wrap/saturate mode and parallel load.
// Define UPDOWN_COUNTER_EDGE_DETECT_EN to step on rising edges of up/down only.
module updown_counter_mod #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             at_zero,
    output logic             at_max,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             carry_q, carry_d;
    logic             borrow_q, borrow_d;
    logic             up_req, dn_req;
    logic             step_up, step_dn;
    logic [WIDTH:0]   cnt_ext, lv_ext, clamp_v, inc_v, dec_v;

`ifdef UPDOWN_COUNTER_EDGE_DETECT_EN
    logic up_q, down_q;

    // History of the raw controls, sampled every cycle for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            up_q   <= 1'b0;
            down_q <= 1'b0;
        end else begin
            up_q   <= up;
            down_q <= down;
        end
    end

    assign up_req = up & ~up_q;
    assign dn_req = down & ~down_q;
`else
    assign up_req = up;
    assign dn_req = down;
`endif

    // Opposing requests in the same cycle cancel into a hold
    assign step_up = up_req & ~dn_req;
    assign step_dn = dn_req & ~up_req;

    assign cnt_ext = {1'b0, count_q};
    assign lv_ext  = {1'b0, load_value};
    assign clamp_v = (lv_ext > MAX) ? MAX : lv_ext;
    assign inc_v   = cnt_ext + ONE;
    assign dec_v   = cnt_ext - ONE;

    // Next count and limit pulses: load beats an enabled step, else hold
    always_comb begin
        count_d  = count_q;
        carry_d  = 1'b0;
        borrow_d = 1'b0;
        if (load) begin
            count_d = clamp_v[WIDTH-1:0];
        end else if (en && step_up) begin
            if (cnt_ext == MAX) begin
                carry_d = 1'b1;
                count_d = (SATURATE != 0) ? count_q : '0;
            end else begin
                count_d = inc_v[WIDTH-1:0];
            end
        end else if (en && step_dn) begin
            if (cnt_ext == '0) begin
                borrow_d = 1'b1;
                count_d  = (SATURATE != 0) ? count_q : MAX[WIDTH-1:0];
            end else begin
                count_d = dec_v[WIDTH-1:0];
            end
        end
    end

    // Count and pulse registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
        end
    end

    assign count   = count_q;
    assign carry   = carry_q;
    assign borrow  = borrow_q;
    assign at_zero = (count_q == '0);
    assign at_max  = (cnt_ext == MAX);

endmodule
